// File: rtl/token_collect.sv
// Token collector: queues nonzero token indices in a small FIFO and writes them to a token-list memory.
// Optional macro TOKEN_COLLECT_DEDUP_EN adds a seen-bitmap that discards repeated tokens within a list.
module token_collect #(
  parameter int INDEX_WIDTH = 10,
  parameter int ADDR_WIDTH  = 9,
  parameter int MAX_TOK     = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic [INDEX_WIDTH:0]  token,
  input  logic                  valid,
  input  logic                  find_finish,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  output logic                  tok_cen,
  output logic                  tok_wen,
  output logic [15:0]           tok_din,
  input  logic                  tok_gnt,
  output logic [ADDR_WIDTH:0]   tok_count,
  output logic                  overflow,
  output logic                  list_done
);

  localparam int TW = INDEX_WIDTH + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d, remain;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [15:0]           din_q, din_d;
  logic [TW-1:0]         head_d;
  logic                  cen_q, cen_d, ovf_q, ovf_d, done_q, done_d;
  logic                  start, commit, dup, cand, full, at_max, drop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write commits only on an edge where the request is already on the bus and granted.
  assign start  = EN && (state_q == IDLE);
  assign commit = EN && !cen_q && tok_gnt;
  assign cand   = EN && (state_q == COLLECT) && valid && (token != '0) && !dup;
  assign full   = (fifo_cnt_q == DEPTH_C);
  assign at_max = (32'(count_q) + 32'(fifo_cnt_q)) >= 32'(MAX_TOK);
  assign drop   = cand && ((full && !commit) || at_max);
  assign push   = cand && !drop;

  always_comb begin
    // NOTE: every next-state signal takes a default first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    waddr_d  = waddr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cen_d    = 1'b1;
    addr_d   = addr_q;
    din_d    = din_q;
    remain   = fifo_cnt_q;
    if (EN) begin
      unique case (state_q)
        IDLE:    state_d = COLLECT;
        COLLECT: if (find_finish) state_d = DRAIN;
        DRAIN:   if ((fifo_cnt_q == '0) && cen_q) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    if (start) begin
      count_d = '0;
      waddr_d = '0;
      ovf_d   = 1'b0;
    end
    if (drop) ovf_d = 1'b1;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (commit) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_q + (ADDR_WIDTH + 1)'(1);
      waddr_d  = waddr_q + ADDR_WIDTH'(1);
      remain   = fifo_cnt_q - CW'(1);
    end
    fifo_cnt_d = remain + CW'(push);
    // An empty FIFO receiving a push presents the incoming token directly.
    head_d = (remain == '0) ? token : fifo_mem[rd_ptr_d];
    if (EN && (fifo_cnt_d != '0)) begin
      cen_d  = 1'b0;
      addr_d = waddr_d;
      din_d  = 16'(head_d);
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      waddr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cen_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      waddr_q    <= waddr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cen_q      <= cen_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      done_q     <= done_d;
    end
  end

  // NOTE: FIFO storage has no reset; the occupancy counter alone defines which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= token;
  end

`ifdef TOKEN_COLLECT_DEDUP_EN
  logic [2**TW-1:0] seen_q;

  always_ff @(posedge CLK) begin
    if (start)     seen_q        <= '0;
    else if (push) seen_q[token] <= 1'b1;
  end

  assign dup = seen_q[token];
`else
  assign dup = 1'b0;
`endif

  assign tok_addr  = addr_q;
  assign tok_cen   = cen_q;
  assign tok_wen   = cen_q;
  assign tok_din   = din_q;
  assign tok_count = count_q;
  assign overflow  = ovf_q;
  assign list_done = done_q;

endmodule

// File: tb/tb_token_collect.sv
// Bench for token_collect: a default instance and a MAX_TOK=2 instance share one stimulus stream and
// are compared against an accepted-token list model; honours TOKEN_COLLECT_DEDUP_EN when defined.
module tb_token_collect;

  localparam int IW    = 10;
  localparam int AW    = 9;
  localparam int DEPTH = 4;
  localparam int A_MAX = 512;
  localparam int B_MAX = 2;

  logic          clk = 1'b0;
  logic          rst, en, valid, find_finish, gnt;
  logic [IW:0]   token;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_cen, a_wen, a_ovf, a_done, b_cen, b_wen, b_ovf, b_done;
  logic [15:0]   a_din, b_din;
  logic [AW:0]   a_count, b_count;

  token_collect #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .MAX_TOK(A_MAX), .FIFO_DEPTH(DEPTH)) dut_a (
    .CLK(clk), .RESET(rst), .EN(en), .token(token), .valid(valid), .find_finish(find_finish),
    .tok_addr(a_addr), .tok_cen(a_cen), .tok_wen(a_wen), .tok_din(a_din), .tok_gnt(gnt),
    .tok_count(a_count), .overflow(a_ovf), .list_done(a_done));

  token_collect #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .MAX_TOK(B_MAX), .FIFO_DEPTH(DEPTH)) dut_b (
    .CLK(clk), .RESET(rst), .EN(en), .token(token), .valid(valid), .find_finish(find_finish),
    .tok_addr(b_addr), .tok_cen(b_cen), .tok_wen(b_wen), .tok_din(b_din), .tok_gnt(gnt),
    .tok_count(b_count), .overflow(b_ovf), .list_done(b_done));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed memory traffic and end-of-list snapshots.
  int          a_wa[$], a_wd[$], b_wa[$], b_wd[$];
  int          a_pulses = 0, b_pulses = 0;
  logic [AW:0] a_dcount, b_dcount;
  logic        a_dovf, b_dovf;

  // Reference model: ordered list of tokens each instance should accept.
  int a_exp[$], b_exp[$];
  int a_held, b_held;
  bit a_movf, b_movf;
  bit a_seen[4096];
  bit b_seen[4096];

  always @(posedge clk) begin
    if (!rst && en && gnt) begin
      if (!a_cen) begin a_wa.push_back(int'(a_addr)); a_wd.push_back(int'(a_din)); end
      if (!b_cen) begin b_wa.push_back(int'(b_addr)); b_wd.push_back(int'(b_din)); end
    end
    if (!rst && a_done) begin a_pulses++; a_dcount = a_count; a_dovf = a_ovf; end
    if (!rst && b_done) begin b_pulses++; b_dcount = b_count; b_dovf = b_ovf; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_new_list();
    a_exp.delete(); b_exp.delete();
    a_held = 0; b_held = 0;
    a_movf = 1'b0; b_movf = 1'b0;
    for (int i = 0; i < 4096; i++) begin a_seen[i] = 1'b0; b_seen[i] = 1'b0; end
    a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
    a_pulses = 0; b_pulses = 0;
  endtask

  // stalled: grant is held low, so nothing accepted in this list has drained yet.
  task automatic model_push(input int tok, input bit stalled);
    bit a_dup, b_dup;
    a_dup = 1'b0; b_dup = 1'b0;
    if (tok == 0) return;
`ifdef TOKEN_COLLECT_DEDUP_EN
    a_dup = a_seen[tok];
    b_dup = b_seen[tok];
`endif
    if (!a_dup) begin
      if (a_exp.size() >= A_MAX || (stalled && a_held >= DEPTH)) a_movf = 1'b1;
      else begin a_exp.push_back(tok); a_held++; a_seen[tok] = 1'b1; end
    end
    if (!b_dup) begin
      if (b_exp.size() >= B_MAX || (stalled && b_held >= DEPTH)) b_movf = 1'b1;
      else begin b_exp.push_back(tok); b_held++; b_seen[tok] = 1'b1; end
    end
  endtask

  task automatic push_tok(input int tok, input bit stalled);
    valid = 1'b1;
    token = (IW + 1)'(tok);
    model_push(tok, stalled);
    step(1);
    valid = 1'b0;
    token = '0;
  endtask

  task automatic compare_list(input string tag);
    check({tag, "_a_nwr"}, a_wa.size(), a_exp.size());
    for (int i = 0; i < a_exp.size(); i++) begin
      if (i < a_wa.size()) begin
        check({tag, "_a_addr"}, a_wa[i], i);
        check({tag, "_a_din"}, a_wd[i], a_exp[i]);
      end
    end
    check({tag, "_b_nwr"}, b_wa.size(), b_exp.size());
    for (int i = 0; i < b_exp.size(); i++) begin
      if (i < b_wa.size()) begin
        check({tag, "_b_addr"}, b_wa[i], i);
        check({tag, "_b_din"}, b_wd[i], b_exp[i]);
      end
    end
    check({tag, "_a_count"}, a_dcount, a_exp.size());
    check({tag, "_a_ovf"}, a_dovf, a_movf);
    check({tag, "_a_pulses"}, a_pulses, 1);
    check({tag, "_b_count"}, b_dcount, b_exp.size());
    check({tag, "_b_ovf"}, b_dovf, b_movf);
    check({tag, "_b_pulses"}, b_pulses, 1);
  endtask

  // After find_finish: one ignored valid in DRAIN, bounded wait for list_done, compare, restart model.
  task automatic finish_tail(input string tag);
    int n;
    valid = 1'b1;
    token = (IW + 1)'(13);
    step(1);
    valid = 1'b0;
    token = '0;
    n = 0;
    while (a_pulses == 0 && n < 200) begin step(1); n++; end
    check({tag, "_done_seen"}, a_pulses != 0, 1);
    step(2);
    check({tag, "_done_low"}, a_done, 0);
    compare_list(tag);
    model_new_list();
  endtask

  task automatic finish_list(input string tag);
    find_finish = 1'b1;
    step(1);
    find_finish = 1'b0;
    finish_tail(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cen"}, a_cen, 1);
    check({tag, "_wen"}, a_wen, 1);
    check({tag, "_addr"}, a_addr, 0);
    check({tag, "_din"}, a_din, 0);
    check({tag, "_count"}, a_count, 0);
    check({tag, "_ovf"}, a_ovf, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_b_ovf"}, b_ovf, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; find_finish = 1'b0; gnt = 1'b1; token = '0;
    model_new_list();
    step(2);
    check_reset_vals("reset");
    rst = 1'b0;
    en  = 1'b1;
    step(2);

    // Basic list: three spaced tokens with a constant grant.
    push_tok(5, 0); step(10);
    push_tok(9, 0); step(10);
    push_tok(12, 0); step(10);
    finish_list("basic");

    // Grant withheld: the FIFO fills, the fifth token is dropped, request holds steady.
    gnt = 1'b0;
    for (int i = 0; i < 5; i++) push_tok(40 + 3 * i, 1);
    step(15);
    check("stall_ovf", a_ovf, 1);
    check("stall_cen", a_cen, 0);
    check("stall_addr", a_addr, 0);
    check("stall_din", a_din, 40);
    gnt = 1'b1;
    finish_list("stall");

    // Tokens 3, 4, 6 (instance B caps at two).
    push_tok(3, 0); step(3);
    push_tok(4, 0); step(3);
    push_tok(6, 0); step(3);
    finish_list("maxtok");

    // Duplicate suppression (expected list depends on the macro).
    push_tok(8, 0); step(3);
    push_tok(8, 0); step(3);
    push_tok(2, 0); step(3);
    push_tok(0, 0); step(3);
    finish_list("dedup");

    // valid and find_finish in the same cycle.
    valid = 1'b1; find_finish = 1'b1; token = (IW + 1)'(7);
    model_push(7, 0);
    step(1);
    valid = 1'b0; find_finish = 1'b0; token = '0;
    finish_tail("same_cycle");

    // EN low freezes everything and releases the bus; the pending write is re-presented afterwards.
    gnt = 1'b0;
    push_tok(21, 1);
    step(2);
    check("en_pend_cen", a_cen, 0);
    en = 1'b0;
    step(1);
    check("en_off_cen", a_cen, 1);
    gnt = 1'b1;
    valid = 1'b1; token = (IW + 1)'(30);
    step(1);
    valid = 1'b0; token = '0;
    step(2);
    check("en_off_nwr", a_wa.size(), 0);
    check("en_off_count", a_count, 0);
    gnt = 1'b0;
    en  = 1'b1;
    step(1);
    check("en_back_cen", a_cen, 0);
    check("en_back_addr", a_addr, 0);
    check("en_back_din", a_din, 21);
    gnt = 1'b1;
    finish_list("en_freeze");

    // Reset mid-list with two tokens queued.
    push_tok(17, 0);
    step(3);
    gnt = 1'b0;
    push_tok(18, 1);
    push_tok(19, 1);
    step(2);
    check("rst_pre_addr", a_addr, 1);
    check("rst_pre_din", a_din, 18);
    check("rst_pre_bovf", b_ovf, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    step(2);
    rst = 1'b0;
    gnt = 1'b1;
    step(6);
    check("rst_nwr", a_wa.size(), 1);
    check("rst_post_cen", a_cen, 1);
    model_new_list();
    push_tok(23, 0);
    step(2);
    finish_list("rst_new");

    // Randomized lists: random valid/token every cycle with grant held high.
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 1) == 1) push_tok(int'($urandom_range(0, 15)), 0);
        else step(1);
      end
      step(2);
      finish_list("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_collect.md
TOKEN_COLLECT -- requirements
Module: token_collect

Interface
REQ-001 The block SHALL expose parameter INDEX_WIDTH, default 10, as the upper bit index of the token bus.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 9, as the token-list memory address width.
REQ-003 The block SHALL expose parameter MAX_TOK, default 512, as the maximum number of tokens stored per list.
REQ-004 The block SHALL expose parameter FIFO_DEPTH, default 4, as the depth of the internal write FIFO.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RESET  in  1  reset, asynchronous, active-high.
REQ-007 EN  in  1  block enable; when low, all state is frozen.
REQ-008 token  in  INDEX_WIDTH+1  1-based crucial token index from the upstream finder.
REQ-009 valid  in  1  single-cycle strobe qualifying token.
REQ-010 find_finish  in  1  single-cycle strobe marking the end of the upstream search.
REQ-011 tok_addr  out  ADDR_WIDTH  token-list memory write address.
REQ-012 tok_cen  out  1  memory chip enable, active-low.
REQ-013 tok_wen  out  1  memory write enable, active-low.
REQ-014 tok_din  out  16  write data, equal to token zero-extended.
REQ-015 tok_gnt  in  1  memory arbitration grant.
REQ-016 tok_count  out  ADDR_WIDTH+1  number of tokens committed to memory.
REQ-017 overflow  out  1  sticky flag: a token was dropped.
REQ-018 list_done  out  1  single-cycle pulse: list complete.

Function
REQ-019 The FSM SHALL have exactly these states and transitions:
- IDLE -> COLLECT on EN=1; the entry cycle clears tok_count, overflow and the write pointer.
- COLLECT -> DRAIN on find_finish=1.
- DRAIN -> DONE when the FIFO is empty and no write is pending.
- DONE -> IDLE after one cycle.
REQ-020 In COLLECT, valid=1 SHALL push token into the FIFO.
- Exception: a token equal to 0 SHALL be silently discarded and SHALL NOT set overflow.
REQ-021 A push SHALL be dropped, setting overflow, when the FIFO is full and no pop occurs in the same cycle.
REQ-022 A push SHALL be dropped, setting overflow, when tok_count plus FIFO occupancy equals MAX_TOK.
REQ-023 Simultaneous push and pop on a full FIFO SHALL succeed, with occupancy unchanged.
REQ-024 valid and find_finish asserted in the same cycle SHALL push the token and then transition to DRAIN.
REQ-025 All memory outputs SHALL be registered; memory writes SHALL behave as follows:
- Drive tok_cen=0, tok_wen=0 with tok_addr = write pointer and tok_din = FIFO head whenever the FIFO is non-empty (COLLECT or DRAIN).
- A write commits on a rising edge where tok_cen=0 and tok_gnt=1; commit pops the FIFO and increments tok_count and the write pointer.
- When tok_gnt=0, tok_cen, tok_wen, tok_addr and tok_din SHALL hold unchanged until granted.
REQ-026 When the FIFO is empty, tok_cen and tok_wen SHALL be 1.
REQ-027 The write pointer SHALL NOT wrap, because MAX_TOK <= 2^ADDR_WIDTH.
REQ-028 valid seen in IDLE, DRAIN or DONE SHALL be ignored.
REQ-029 find_finish seen outside COLLECT SHALL be ignored.
REQ-030 list_done SHALL be 1 only in DONE.
REQ-031 tok_count and overflow SHALL hold their values from DONE until the next IDLE -> COLLECT transition.
REQ-032 When EN=0, there SHALL be no state transition, no push, no commit and no counter change, and tok_cen SHALL be 1.
- On EN returning to 1, a write still pending SHALL re-present the same address and data with tok_cen=0.

Reset
REQ-033 On RESET=1, the block SHALL asynchronously clear to the following values:
- State IDLE and FIFO empty.
- tok_cen=1, tok_wen=1, tok_addr=0, tok_din=0.
- tok_count=0, overflow=0, list_done=0.
REQ-034 RESET asserted mid-list SHALL discard FIFO contents, and no write SHALL commit in the reset cycle.

Configuration
REQ-035 Macro TOKEN_COLLECT_DEDUP_EN SHALL control duplicate suppression:
- Defined: a 2^(INDEX_WIDTH+1)-bit seen-bitmap is cleared on IDLE -> COLLECT; a token whose bit is already set SHALL be discarded without setting overflow; an accepted push sets the bit.
- Undefined: no bitmap exists and every nonzero token is pushed.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- EN=1; tokens 5, 9, 12 each with valid, 10 idle cycles apart; tok_gnt=1; then find_finish -> writes (0,5), (1,9), (2,12); tok_count=3; list_done one cycle; overflow=0.
- tok_gnt=0 for 20 cycles with 4 tokens pushed, then a 5th token -> 5th dropped, overflow=1; after grant, exactly 4 writes at addresses 0-3.
- MAX_TOK=2 with tokens 3, 4, 6 -> only 3 and 4 written; overflow=1; tok_count=2.
- token 7 with valid and find_finish in the same cycle -> 7 written at address 0, then list_done.
- RESET pulsed while 2 tokens are queued -> no further writes; all outputs at reset values; a new list starts at address 0.
- TOKEN_COLLECT_DEDUP_EN defined, tokens 8, 8, 2 -> writes 8 and 2 only; tok_count=2; overflow=0.
